// File: rtl/spi_rx_deser_pkg.sv
// Shared types and widths for the SPI receive deserializer.
package spi_deser_pkg;

    localparam int BYTE_W    = 8;
    localparam int BIT_CNT_W = 3;

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

    // Shift one received bit into the byte in the configured order.
    function automatic logic [BYTE_W-1:0] shift_in(input logic [BYTE_W-1:0] cur,
                                                   input logic              b,
                                                   input logic              msb_first);
        return msb_first ? {cur[BYTE_W-2:0], b} : {b, cur[BYTE_W-1:1]};
    endfunction

endpackage

// File: rtl/spi_rx_deser_sync.sv
// Single-bit multi-flop synchronizer with a configurable reset level.
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ff <= {STAGES{RST_VAL}};
        else     ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_rx_deser.sv
// SPI mode-0 slave receiver: oversampled SCLK/CS_N/MOSI, byte assembly, valid/ready hand-off.
// Optional MISO echo of the last delivered byte is enabled with SPI_RX_DESER_MISO_EN.
module spi_rx_deser
    import spi_deser_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MSB_FIRST   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_overrun,
    output logic              rx_abort
);

    localparam logic MSB = (MSB_FIRST != 0);

    logic sclk_s, cs_s, mosi_s;
    logic sclk_d, cs_d;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .d(spi_sclk), .q(sclk_s));
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .d(spi_cs_n), .q(cs_s));
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .d(spi_mosi), .q(mosi_s));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_d <= 1'b0;
            cs_d   <= 1'b1;
        end else begin
            sclk_d <= sclk_s;
            cs_d   <= cs_s;
        end
    end

    wire sclk_rise = sclk_s & ~sclk_d;
    wire cs_rise   = cs_s & ~cs_d;
    wire cs_fall   = ~cs_s & cs_d;

    // After reset the CS_N synchronizer holds its idle level until it has flushed;
    // a fall seen then is only the real line showing through, not a new frame.
    // Frames are accepted once a flushed CS_N high has actually been observed.
    logic [SYNC_STAGES-1:0] settle;
    logic                   armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle <= '0;
            armed  <= 1'b0;
        end else begin
            settle <= {settle[SYNC_STAGES-2:0], 1'b1};
            armed  <= armed | (settle[SYNC_STAGES-1] & cs_s);
        end
    end

    wire frame_start = cs_fall & armed;

    state_t               state, state_nxt;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [BYTE_W-1:0]    shreg;
    logic [BYTE_W-1:0]    byte_nxt;
    logic                 shift_en, byte_done, abort_now;

    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        byte_done = 1'b0;
        abort_now = 1'b0;
        byte_nxt  = shift_in(shreg, mosi_s, MSB);
        case (state)
            ST_IDLE: begin
                if (frame_start) state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                shift_en  = sclk_rise;
                byte_done = sclk_rise & (&bit_cnt);
                // A bit landing with CS_N rise counts toward the byte before abort is judged.
                abort_now = cs_rise & (sclk_rise ? ~(&bit_cnt) : (bit_cnt != '0));
                if (cs_rise) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (cs_rise || frame_start) begin
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (shift_en) begin
            bit_cnt <= bit_cnt + 1'b1;
            shreg   <= byte_nxt;
        end
    end

    // Holding register: a completing byte loads unless an unconsumed byte is still parked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
            rx_abort   <= 1'b0;
        end else begin
            rx_abort <= abort_now;
            if (byte_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= byte_nxt;
                    rx_valid <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (frame_start) rx_overrun <= 1'b0;
        end
    end

`ifdef SPI_RX_DESER_MISO_EN
    wire sclk_fall = ~sclk_s & sclk_d;
    logic [BYTE_W-1:0] tx_reg;

    // Preloaded at frame start so the first bit is on the wire before the first rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tx_reg <= '0;
        else if (state == ST_IDLE && frame_start)
            tx_reg <= rx_data;
        else if (state == ST_SHIFT && sclk_fall)
            tx_reg <= MSB ? {tx_reg[BYTE_W-2:0], 1'b0} : {1'b0, tx_reg[BYTE_W-1:1]};
    end

    assign spi_miso = MSB ? tx_reg[BYTE_W-1] : tx_reg[0];
`else
    assign spi_miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_rx_deser.sv
// Directed bench for spi_rx_deser: one MSB-first and one LSB-first instance share the SPI bus.
module tb_spi_rx_deser;

    localparam int S    = 2;
    localparam int HALF = 4;

`ifdef SPI_RX_DESER_MISO_EN
    localparam logic [7:0] MISO_EXP = 8'h3C;
`else
    localparam logic [7:0] MISO_EXP = 8'h00;
`endif

    logic clk = 1'b0, rst = 1'b1;
    logic sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0, rx_ready = 1'b0;
    logic       miso_m, valid_m, ovr_m, abort_m;
    logic       miso_l, valid_l, ovr_l, abort_l;
    logic [7:0] data_m, data_l;

    spi_rx_deser #(.SYNC_STAGES(S), .MSB_FIRST(1)) dut (
        .clk(clk), .rst(rst), .spi_sclk(sclk), .spi_cs_n(cs_n), .spi_mosi(mosi),
        .spi_miso(miso_m), .rx_data(data_m), .rx_valid(valid_m), .rx_ready(rx_ready),
        .rx_overrun(ovr_m), .rx_abort(abort_m));

    spi_rx_deser #(.SYNC_STAGES(S), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst(rst), .spi_sclk(sclk), .spi_cs_n(cs_n), .spi_mosi(mosi),
        .spi_miso(miso_l), .rx_data(data_l), .rx_valid(valid_l), .rx_ready(rx_ready),
        .rx_overrun(ovr_l), .rx_abort(abort_l));

    always #5 clk = ~clk;

    int n_pass = 0, n_total = 0;
    int vcyc_m, vcyc_l, ab_m, ab_l;
    logic [7:0] last_m, last_l;
    logic clr = 1'b0;

    always @(negedge clk) begin
        if (clr || rst) begin
            vcyc_m = 0; vcyc_l = 0; ab_m = 0; ab_l = 0;
        end else begin
            if (valid_m) begin vcyc_m++; last_m = data_m; end
            if (valid_l) begin vcyc_l++; last_l = data_l; end
            if (abort_m) ab_m++;
            if (abort_l) ab_l++;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_counts();
        clr = 1'b1;
        @(negedge clk);
        #1 clr = 1'b0;
    endtask

    // Send the first n bits of b, bit 7 first; MISO of both instances sampled just before each rise.
    task automatic send_bits(input logic [7:0] b, input int n,
                             output logic [7:0] mm, output logic [7:0] ml);
        mm = '0;
        ml = '0;
        for (int i = 0; i < n; i++) begin
            mosi = b[7-i];
            wait_neg(HALF);
            mm[7-i] = miso_m;
            ml[7-i] = miso_l;
            sclk = 1'b1;
            wait_neg(HALF);
            sclk = 1'b0;
        end
    endtask

    task automatic frame(input logic [7:0] b, output logic [7:0] mm, output logic [7:0] ml);
        cs_n = 1'b0;
        wait_neg(6);
        send_bits(b, 8, mm, ml);
        wait_neg(HALF);
        cs_n = 1'b1;
        wait_neg(8);
    endtask

    typedef struct {
        logic [7:0] tx;
        logic [7:0] exp_m;
        logic [7:0] exp_l;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [7:0] mm, ml;
        int n;

        tbl[0] = '{8'hB5, 8'hB5, 8'hAD};
        tbl[1] = '{8'h00, 8'h00, 8'h00};
        tbl[2] = '{8'hFF, 8'hFF, 8'hFF};
        tbl[3] = '{8'h01, 8'h01, 8'h80};
        tbl[4] = '{8'hA5, 8'hA5, 8'hA5};
        tbl[5] = '{8'h3C, 8'h3C, 8'h3C};

        // reset state
        wait_neg(3);
        check("rst_data", {24'h0, data_m}, 0);
        check("rst_valid", {31'h0, valid_m}, 0);
        check("rst_ovr", {31'h0, ovr_m}, 0);
        check("rst_abort", {31'h0, abort_m}, 0);
        check("rst_miso", {31'h0, miso_m}, 0);
        rst = 1'b0;
        wait_neg(6);

        // B5 with latency measured from the 8th SCLK rise
        rx_ready = 1'b1;
        clear_counts();
        cs_n = 1'b0;
        wait_neg(6);
        send_bits(8'hB5, 7, mm, ml);
        mosi = 1'b1;
        wait_neg(HALF);
        sclk = 1'b1;
        n = 0;
        while (!valid_m && n < 10) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check("latency", n, S + 1);
        check("lat_data", {24'h0, data_m}, 32'hB5);
        wait_neg(HALF);
        sclk = 1'b0;
        wait_neg(HALF);
        cs_n = 1'b1;
        wait_neg(8);
        check("lat_vpulse", vcyc_m, 1);

        // single-byte frames with immediate consumption
        for (int i = 0; i < 6; i++) begin
            clear_counts();
            frame(tbl[i].tx, mm, ml);
            check($sformatf("tbl%0d_msb", i), {24'h0, last_m}, {24'h0, tbl[i].exp_m});
            check($sformatf("tbl%0d_lsb", i), {24'h0, last_l}, {24'h0, tbl[i].exp_l});
            check($sformatf("tbl%0d_vm", i), vcyc_m, 1);
            check($sformatf("tbl%0d_vl", i), vcyc_l, 1);
        end

        // MISO echo of 3C in the following frame
        frame(8'h00, mm, ml);
        check("miso_lsb", {24'h0, ml}, {24'h0, MISO_EXP});
        check("miso_msb", {24'h0, mm}, {24'h0, MISO_EXP});

        // overrun: 12 then 34 with nobody consuming
        rx_ready = 1'b0;
        cs_n = 1'b0;
        wait_neg(6);
        send_bits(8'h12, 8, mm, ml);
        send_bits(8'h34, 8, mm, ml);
        wait_neg(HALF);
        cs_n = 1'b1;
        wait_neg(8);
        check("ovr_valid", {31'h0, valid_m}, 1);
        check("ovr_data_m", {24'h0, data_m}, 32'h12);
        check("ovr_data_l", {24'h0, data_l}, 32'h48);
        check("ovr_flag_m", {31'h0, ovr_m}, 1);
        check("ovr_flag_l", {31'h0, ovr_l}, 1);
        rx_ready = 1'b1;
        wait_neg(2);
        rx_ready = 1'b0;
        check("ovr_consumed", {31'h0, valid_m}, 0);
        check("ovr_sticky", {31'h0, ovr_m}, 1);
        cs_n = 1'b0;
        wait_neg(6);
        check("ovr_clr_m", {31'h0, ovr_m}, 0);
        check("ovr_clr_l", {31'h0, ovr_l}, 0);

        // second byte completes in the handshake cycle of the first
        send_bits(8'h12, 8, mm, ml);
        check("sim_first", {24'h0, data_m}, 32'h12);
        send_bits(8'h34, 7, mm, ml);
        mosi = 1'b0;
        wait_neg(HALF);
        sclk = 1'b1;
        repeat (S) @(posedge clk);
        @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check("sim_valid", {31'h0, valid_m}, 1);
        check("sim_data_m", {24'h0, data_m}, 32'h34);
        check("sim_data_l", {24'h0, data_l}, 32'h2C);
        check("sim_ovr", {31'h0, ovr_m}, 0);
        wait_neg(HALF);
        sclk = 1'b0;
        wait_neg(HALF);
        cs_n = 1'b1;
        rx_ready = 1'b1;
        wait_neg(8);

        // abort after 5 bits, then a clean A5 frame
        clear_counts();
        cs_n = 1'b0;
        wait_neg(6);
        send_bits(8'hA5, 5, mm, ml);
        wait_neg(HALF);
        cs_n = 1'b1;
        wait_neg(8);
        check("abort_pulse_m", ab_m, 1);
        check("abort_pulse_l", ab_l, 1);
        check("abort_novalid", vcyc_m, 0);
        clear_counts();
        frame(8'hA5, mm, ml);
        check("abort_next_m", {24'h0, last_m}, 32'hA5);
        check("abort_next_v", vcyc_m, 1);
        check("abort_none", ab_m, 0);

        // reset after 4 bits of a frame
        cs_n = 1'b0;
        wait_neg(6);
        send_bits(8'hFF, 4, mm, ml);
        rst = 1'b1;
        #1;
        check("mrst_data_m", {24'h0, data_m}, 0);
        check("mrst_data_l", {24'h0, data_l}, 0);
        check("mrst_valid", {31'h0, valid_m}, 0);
        check("mrst_ovr", {31'h0, ovr_m}, 0);
        check("mrst_abort", {31'h0, abort_m}, 0);
        check("mrst_miso", {31'h0, miso_m}, 0);
        wait_neg(2);
        rst = 1'b0;
        clear_counts();
        send_bits(8'hC3, 8, mm, ml);
        wait_neg(HALF);
        check("mrst_nobyte", vcyc_m, 0);
        cs_n = 1'b1;
        wait_neg(8);
        check("mrst_noabort", ab_m, 0);
        clear_counts();
        frame(8'h5A, mm, ml);
        check("mrst_after_m", {24'h0, last_m}, 32'h5A);
        check("mrst_after_v", vcyc_m, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/spi_rx_deser.md
SPI_RX_DESER -- requirements
Module: spi_rx_deser

Interface
REQ-001 The module SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth for SCLK/CS_N/MOSI (legal 2..4).
REQ-002 The module SHALL have parameter MSB_FIRST, default 1, meaning 1 = first received bit lands in rx_data[7] and 0 = first bit lands in rx_data[0].
REQ-003 The module SHALL have port clk, input, 1 bit: the single system clock.
REQ-004 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port spi_sclk, input, 1 bit: SPI mode-0 serial clock, asynchronous to clk.
REQ-006 The module SHALL have port spi_cs_n, input, 1 bit: active-low chip select, asynchronous.
REQ-007 The module SHALL have port spi_mosi, input, 1 bit: serial data in.
REQ-008 The module SHALL have port spi_miso, output, 1 bit: serial data out (see Configuration).
REQ-009 The module SHALL have port rx_data, output, 8 bits: assembled byte delivered to the downstream XOR-cipher stage.
REQ-010 The module SHALL have port rx_valid, output, 1 bit: rx_data holds an unconsumed byte.
REQ-011 The module SHALL have port rx_ready, input, 1 bit: the downstream stage accepts the byte this cycle.
REQ-012 The module SHALL have port rx_overrun, output, 1 bit: sticky flag, a completed byte was dropped.
REQ-013 The module SHALL have port rx_abort, output, 1 bit: one-cycle pulse, the frame ended with a partial byte.

Function
REQ-014 spi_sclk, spi_cs_n and spi_mosi SHALL each pass through SYNC_STAGES flops before use; edges SHALL be detected by comparing the last synchronizer stage with one extra history flop.
REQ-015 The FSM SHALL have two states: IDLE (synchronized CS_N high) and SHIFT (synchronized CS_N low); IDLE->SHIFT on the CS_N fall, and SHIFT->IDLE on the CS_N rise.
REQ-016 In SHIFT, each synchronized SCLK rise SHALL shift synchronized MOSI into a 3-bit-counted shift register; SCLK edges in IDLE SHALL be ignored.
REQ-017 On the 8th rise, the byte SHALL load into the rx_data holding register, rx_valid SHALL set, and the bit counter SHALL wrap to 0 for back-to-back bytes within a frame.
REQ-018 Latency: rx_valid SHALL be high in the cycle after clk edge k+SYNC_STAGES, where k is the first clk edge sampling the 8th SCLK high.
REQ-019 Handshake: rx_valid SHALL clear on the clk edge where rx_valid and rx_ready are both high, and rx_data SHALL hold stable while rx_valid is high and rx_ready is low.
REQ-020 Simultaneous events: if a byte completes in the same cycle as rx_valid and rx_ready, the new byte SHALL load, rx_valid SHALL stay high, and rx_overrun SHALL NOT set.
REQ-021 Full: if a byte completes while rx_valid is high and rx_ready is low, the new byte SHALL be dropped, rx_data SHALL be kept, and rx_overrun SHALL set.
REQ-022 rx_overrun SHALL clear only on a synchronized CS_N fall or on reset.
REQ-023 A CS_N rise with a nonzero bit counter SHALL discard the partial bits, zero the counter, and pulse rx_abort for exactly one cycle; a pending rx_valid byte SHALL be kept.
REQ-024 The required operating condition SHALL be an SCLK period of at least 4 clk periods, with high and low phases of at least 2 clk periods each.

Reset
REQ-025 rst SHALL asynchronously force: state IDLE, synchronizers to idle levels (SCLK 0, CS_N 1, MOSI 0), bit counter 0, shift register 0, rx_data 8'h00, rx_valid 0, rx_overrun 0, rx_abort 0, spi_miso 0.
REQ-026 Reset asserted mid-frame SHALL drop all partial and pending data, and the first byte after release SHALL require a fresh CS_N fall.

Configuration
REQ-027 Macro SPI_RX_DESER_MISO_EN SHALL control the MISO echo feature.
REQ-028 With SPI_RX_DESER_MISO_EN defined, on each CS_N fall spi_miso SHALL preload the last accepted rx_data and SHALL shift it out in the same bit order as MSB_FIRST.
REQ-029 With SPI_RX_DESER_MISO_EN defined, spi_miso SHALL update after each synchronized SCLK fall, and the first bit SHALL be valid before the first rise.
REQ-030 Without SPI_RX_DESER_MISO_EN, spi_miso SHALL be constant 0 and no transmit register SHALL exist.

Structure
REQ-031 Package spi_deser_pkg SHALL hold the FSM state enum (ST_IDLE, ST_SHIFT), BYTE_W = 8, and BIT_CNT_W = 3.
REQ-032 Sub-module spi_sync SHALL implement one parameterized-depth bit synchronizer with reset value as a parameter, instantiated three times.

Verification
REQ-033 The bench SHALL cover: CS_N low, MOSI bits 1,0,1,1,0,1,0,1, rx_ready = 1 -> one rx_valid pulse with rx_data = 8'hB5 at the specified latency.
REQ-034 The bench SHALL cover: frame 8'h12, 8'h34 back-to-back with rx_ready = 0 -> rx_data = 8'h12 held, rx_overrun = 1; after the next CS_N fall -> rx_overrun = 0.
REQ-035 The bench SHALL cover: the second byte completing in the same cycle as the first byte's handshake -> rx_data = second byte, rx_valid stays 1, rx_overrun = 0.
REQ-036 The bench SHALL cover: CS_N rising after 5 bits -> rx_abort is a single 1-cycle pulse, no rx_valid, and the next frame sending 8'hA5 yields 8'hA5.
REQ-037 The bench SHALL cover: rst pulsed after 4 bits of a frame -> all outputs at reset values immediately, no byte delivered until a new CS_N fall.
REQ-038 The bench SHALL cover: with SPI_RX_DESER_MISO_EN and MSB_FIRST = 0, after receiving 8'h3C -> the next frame's MISO sequence is 0,0,1,1,1,1,0,0; without the macro -> MISO is always 0.
